// File: rtl/rvh_tlb_flush_sequencer.sv
// rtl/rvh_tlb_flush_sequencer.sv - serialises DTLB/ITLB flush requests onto the shared MMU flush port
// Round-robin between requesters, merges identical requests, drains page walks before each flush.
module rvh_tlb_flush_sequencer #(
  parameter int VPN_WIDTH  = 27,
  parameter int ASID_WIDTH = 16,
  parameter int DRAIN_MAX  = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dtlb_flush_vld_i,
  input  logic                  dtlb_flush_use_asid_i,
  input  logic                  dtlb_flush_use_vpn_i,
  input  logic [VPN_WIDTH-1:0]  dtlb_flush_vpn_i,
  input  logic [ASID_WIDTH-1:0] dtlb_flush_asid_i,
  output logic                  dtlb_flush_grant_o,
  input  logic                  itlb_flush_vld_i,
  input  logic                  itlb_flush_use_asid_i,
  input  logic                  itlb_flush_use_vpn_i,
  input  logic [VPN_WIDTH-1:0]  itlb_flush_vpn_i,
  input  logic [ASID_WIDTH-1:0] itlb_flush_asid_i,
  output logic                  itlb_flush_grant_o,
  input  logic                  ptw_busy_i,
  output logic                  miss_req_block_o,
  output logic                  mmu_flush_vld_o,
  output logic                  mmu_flush_use_asid_o,
  output logic                  mmu_flush_use_vpn_o,
  output logic [VPN_WIDTH-1:0]  mmu_flush_vpn_o,
  output logic [ASID_WIDTH-1:0] mmu_flush_asid_o,
  input  logic                  mmu_flush_grant_i,
  output logic                  drain_timeout_o
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_GRANT
  } state_t;

  state_t           state;
  logic             rr_ptr;      // 0: DTLB wins the next contention, 1: ITLB
  logic [1:0]       mask;        // {itlb, dtlb}: just granted, ignore a late-dropping vld
  logic             win_d;
  logic             win_i;
  logic [CNT_W-1:0] drain_cnt;

  logic elig_d;
  logic elig_i;
  logic same_req;
  logic pick_d;
  logic pick_i;

  always_comb begin
    elig_d   = dtlb_flush_vld_i & ~mask[0];
    elig_i   = itlb_flush_vld_i & ~mask[1];
    same_req = (dtlb_flush_use_asid_i == itlb_flush_use_asid_i) &&
               (dtlb_flush_use_vpn_i  == itlb_flush_use_vpn_i)  &&
               (dtlb_flush_vpn_i      == itlb_flush_vpn_i)      &&
               (dtlb_flush_asid_i     == itlb_flush_asid_i);
    pick_d   = elig_d & (~elig_i | same_req | ~rr_ptr);
    pick_i   = elig_i & (~elig_d | same_req |  rr_ptr);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state                <= S_IDLE;
      rr_ptr               <= 1'b0;
      mask                 <= 2'b00;
      win_d                <= 1'b0;
      win_i                <= 1'b0;
      drain_cnt            <= '0;
      miss_req_block_o     <= 1'b0;
      mmu_flush_vld_o      <= 1'b0;
      mmu_flush_use_asid_o <= 1'b0;
      mmu_flush_use_vpn_o  <= 1'b0;
      mmu_flush_vpn_o      <= '0;
      mmu_flush_asid_o     <= '0;
      dtlb_flush_grant_o   <= 1'b0;
      itlb_flush_grant_o   <= 1'b0;
      drain_timeout_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mask <= 2'b00;
          if (pick_d | pick_i) begin
            mmu_flush_use_asid_o <= pick_d ? dtlb_flush_use_asid_i : itlb_flush_use_asid_i;
            mmu_flush_use_vpn_o  <= pick_d ? dtlb_flush_use_vpn_i  : itlb_flush_use_vpn_i;
            mmu_flush_vpn_o      <= pick_d ? dtlb_flush_vpn_i      : itlb_flush_vpn_i;
            mmu_flush_asid_o     <= pick_d ? dtlb_flush_asid_i     : itlb_flush_asid_i;
            win_d                <= pick_d;
            win_i                <= pick_i;
            if (elig_d & elig_i & ~same_req) begin
              rr_ptr <= ~rr_ptr;
            end
            miss_req_block_o <= 1'b1;
            state            <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt != CNT_MAX) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
          // The count reaching DRAIN_MAX only flags the stall; the walk is still awaited.
          if (drain_cnt >= CNT_LAST) begin
            drain_timeout_o <= 1'b1;
          end
          if (!ptw_busy_i) begin
            mmu_flush_vld_o <= 1'b1;
            state           <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (mmu_flush_grant_i) begin
            mmu_flush_vld_o    <= 1'b0;
            miss_req_block_o   <= 1'b0;
            dtlb_flush_grant_o <= win_d;
            itlb_flush_grant_o <= win_i;
            state              <= S_GRANT;
          end
        end
        S_GRANT: begin
          dtlb_flush_grant_o <= 1'b0;
          itlb_flush_grant_o <= 1'b0;
          mask               <= {win_i, win_d};
          drain_cnt          <= '0;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvh_tlb_flush_sequencer.sv
// tb/tb_rvh_tlb_flush_sequencer.sv - directed and randomized bench for rvh_tlb_flush_sequencer
// Episode-level model: each captured flush gets a drain length and MMU delay, outputs follow by arithmetic.
module tb_rvh_tlb_flush_sequencer;

  localparam int VW  = 27;
  localparam int AW  = 16;
  localparam int DM  = 64;
  localparam int BIG = 1 << 30;

  typedef struct packed {
    logic          ua;
    logic          uv;
    logic [VW-1:0] vpn;
    logic [AW-1:0] asid;
  } fl_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          dtlb_flush_vld_i, dtlb_flush_use_asid_i, dtlb_flush_use_vpn_i;
  logic [VW-1:0] dtlb_flush_vpn_i;
  logic [AW-1:0] dtlb_flush_asid_i;
  logic          dtlb_flush_grant_o;
  logic          itlb_flush_vld_i, itlb_flush_use_asid_i, itlb_flush_use_vpn_i;
  logic [VW-1:0] itlb_flush_vpn_i;
  logic [AW-1:0] itlb_flush_asid_i;
  logic          itlb_flush_grant_o;
  logic          ptw_busy_i, miss_req_block_o, mmu_flush_vld_o;
  logic          mmu_flush_use_asid_o, mmu_flush_use_vpn_o;
  logic [VW-1:0] mmu_flush_vpn_o;
  logic [AW-1:0] mmu_flush_asid_o;
  logic          mmu_flush_grant_i, drain_timeout_o;

  rvh_tlb_flush_sequencer #(.VPN_WIDTH(VW), .ASID_WIDTH(AW), .DRAIN_MAX(DM)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .dtlb_flush_vld_i      (dtlb_flush_vld_i),
    .dtlb_flush_use_asid_i (dtlb_flush_use_asid_i),
    .dtlb_flush_use_vpn_i  (dtlb_flush_use_vpn_i),
    .dtlb_flush_vpn_i      (dtlb_flush_vpn_i),
    .dtlb_flush_asid_i     (dtlb_flush_asid_i),
    .dtlb_flush_grant_o    (dtlb_flush_grant_o),
    .itlb_flush_vld_i      (itlb_flush_vld_i),
    .itlb_flush_use_asid_i (itlb_flush_use_asid_i),
    .itlb_flush_use_vpn_i  (itlb_flush_use_vpn_i),
    .itlb_flush_vpn_i      (itlb_flush_vpn_i),
    .itlb_flush_asid_i     (itlb_flush_asid_i),
    .itlb_flush_grant_o    (itlb_flush_grant_o),
    .ptw_busy_i            (ptw_busy_i),
    .miss_req_block_o      (miss_req_block_o),
    .mmu_flush_vld_o       (mmu_flush_vld_o),
    .mmu_flush_use_asid_o  (mmu_flush_use_asid_o),
    .mmu_flush_use_vpn_o   (mmu_flush_use_vpn_o),
    .mmu_flush_vpn_o       (mmu_flush_vpn_o),
    .mmu_flush_asid_o      (mmu_flush_asid_o),
    .mmu_flush_grant_i     (mmu_flush_grant_i),
    .drain_timeout_o       (drain_timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  // Requester agents: index 0 = DTLB, 1 = ITLB
  logic act[2];
  logic dropped[2];
  fl_t  fld[2];
  int   hold_until[2];
  int   next_start[2];
  int   last_gnt[2];

  // Model of the current flush episode
  logic       ep_active;
  int         cap, ep_b, ep_d;
  logic [1:0] ep_w;
  fl_t        ep_fld;
  logic       rr_m;
  logic       exp_to;
  int         free_at;

  logic en_rand;
  int   f_b, f_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic fl_t mk(input logic ua, input logic uv, input logic [VW-1:0] vpn,
                             input logic [AW-1:0] asid);
    fl_t f;
    f.ua = ua; f.uv = uv; f.vpn = vpn; f.asid = asid;
    return f;
  endfunction

  function automatic fl_t rand_fl();
    return mk(1'($urandom), 1'($urandom), VW'($urandom), AW'($urandom));
  endfunction

  task automatic start_req(input int r, input fl_t f);
    act[r] = 1'b1; dropped[r] = 1'b0; fld[r] = f; hold_until[r] = BIG;
  endtask

  task automatic drive_zero();
    dtlb_flush_vld_i = 0; dtlb_flush_use_asid_i = 0; dtlb_flush_use_vpn_i = 0;
    dtlb_flush_vpn_i = '0; dtlb_flush_asid_i = '0;
    itlb_flush_vld_i = 0; itlb_flush_use_asid_i = 0; itlb_flush_use_vpn_i = 0;
    itlb_flush_vpn_i = '0; itlb_flush_asid_i = '0;
    ptw_busy_i = 0; mmu_flush_grant_i = 0;
  endtask

  task automatic reset_model();
    for (int r = 0; r < 2; r++) begin
      act[r] = 0; dropped[r] = 0; fld[r] = '0;
      hold_until[r] = BIG; next_start[r] = 0; last_gnt[r] = -10;
    end
    ep_active = 0; cap = 0; ep_b = 0; ep_d = 0; ep_w = 2'b00; ep_fld = '0;
    rr_m = 0; exp_to = 0; free_at = 0;
    drive_zero();
  endtask

  task automatic outputs_zero(input string tag);
    check_eq({tag, "_block"}, 32'(miss_req_block_o), 32'd0);
    check_eq({tag, "_vld"}, 32'(mmu_flush_vld_o), 32'd0);
    check_eq({tag, "_use_asid"}, 32'(mmu_flush_use_asid_o), 32'd0);
    check_eq({tag, "_use_vpn"}, 32'(mmu_flush_use_vpn_o), 32'd0);
    check_eq({tag, "_vpn"}, 32'(mmu_flush_vpn_o), 32'd0);
    check_eq({tag, "_asid"}, 32'(mmu_flush_asid_o), 32'd0);
    check_eq({tag, "_gnt_d"}, 32'(dtlb_flush_grant_o), 32'd0);
    check_eq({tag, "_gnt_i"}, 32'(itlb_flush_grant_o), 32'd0);
    check_eq({tag, "_timeout"}, 32'(drain_timeout_o), 32'd0);
  endtask

  task automatic update_agents(input int c);
    fl_t f, g;
    for (int r = 0; r < 2; r++) begin
      if (act[r] && c > hold_until[r]) begin
        act[r] = 0; dropped[r] = 0; hold_until[r] = BIG;
        next_start[r] = c + 1 + int'($urandom_range(0, 3));
      end else if (act[r] && hold_until[r] != BIG && $urandom_range(0, 31) == 0) begin
        dropped[r] = 1'b1;
      end
    end
    if (en_rand) begin
      if (!act[0] && !act[1] && c >= next_start[0] && c >= next_start[1] &&
          $urandom_range(0, 2) == 0) begin
        f = rand_fl();
        g = f;
        case ($urandom_range(0, 7))
          0: g.ua = ~g.ua;
          1: g.uv = ~g.uv;
          2: g.vpn = g.vpn ^ (VW'(1) << $urandom_range(0, VW - 1));
          3: g.asid = g.asid ^ (AW'(1) << $urandom_range(0, AW - 1));
          default: ;
        endcase
        start_req(0, f);
        start_req(1, g);
      end else begin
        for (int r = 0; r < 2; r++)
          if (!act[r] && c >= next_start[r] && $urandom_range(0, 1) == 0) start_req(r, rand_fl());
      end
    end
  endtask

  function automatic int pick_b();
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 0) return DM - 3 + int'($urandom_range(0, 5));
    if (r < 6) return int'($urandom_range(4, 12));
    return int'($urandom_range(0, 3));
  endfunction

  task automatic capture(input int c);
    logic e0, e1;
    int   g;
    if (ep_active || c < free_at) return;
    e0 = act[0] && !dropped[0] && (last_gnt[0] != c - 1);
    e1 = act[1] && !dropped[1] && (last_gnt[1] != c - 1);
    if (!(e0 || e1)) return;
    if (e0 && e1) begin
      if (fld[0] == fld[1]) ep_w = 2'b11;
      else begin
        ep_w = rr_m ? 2'b10 : 2'b01;
        rr_m = ~rr_m;
      end
    end else begin
      ep_w = {e1, e0};
    end
    ep_active = 1'b1;
    cap  = c;
    ep_b = (f_b >= 0) ? f_b : pick_b();
    ep_d = (f_d >= 0) ? f_d : int'($urandom_range(0, 4));
    ep_fld = ep_w[0] ? fld[0] : fld[1];
    g = cap + ep_b + 3 + ep_d;
    for (int r = 0; r < 2; r++)
      if (ep_w[r]) begin
        last_gnt[r] = g;
        hold_until[r] = g + int'($urandom_range(0, 1));
      end
    free_at = g + 1;
  endtask

  task automatic drive(input int c);
    int s;
    s = ep_active ? c - cap : -1;
    dtlb_flush_vld_i = act[0] && !dropped[0];
    dtlb_flush_use_asid_i = fld[0].ua; dtlb_flush_use_vpn_i = fld[0].uv;
    dtlb_flush_vpn_i = fld[0].vpn; dtlb_flush_asid_i = fld[0].asid;
    itlb_flush_vld_i = act[1] && !dropped[1];
    itlb_flush_use_asid_i = fld[1].ua; itlb_flush_use_vpn_i = fld[1].uv;
    itlb_flush_vpn_i = fld[1].vpn; itlb_flush_asid_i = fld[1].asid;
    if (ep_active && s >= 1 && s <= ep_b) ptw_busy_i = 1'b1;
    else if (ep_active && s == ep_b + 1) ptw_busy_i = 1'b0;
    else ptw_busy_i = 1'($urandom);
    if (ep_active && s >= ep_b + 2 && s <= ep_b + 2 + ep_d) mmu_flush_grant_i = (s == ep_b + 2 + ep_d);
    else mmu_flush_grant_i = ($urandom_range(0, 3) == 0);
  endtask

  task automatic step();
    int   c, s, g;
    logic e_blk, e_vld, e_gd, e_gi;
    @(posedge clk);
    #1;
    c = cyc;
    if (ep_active && c > cap + ep_b + 3 + ep_d) ep_active = 1'b0;
    e_blk = 0; e_vld = 0; e_gd = 0; e_gi = 0;
    if (ep_active) begin
      s = c - cap;
      g = ep_b + 3 + ep_d;
      e_blk = (s >= 1) && (s < g);
      e_vld = (s >= ep_b + 2) && (s < g);
      e_gd  = (s == g) && ep_w[0];
      e_gi  = (s == g) && ep_w[1];
      if (ep_b + 1 >= DM && s == DM + 1) exp_to = 1'b1;
    end
    check_eq("miss_block", 32'(miss_req_block_o), 32'(e_blk));
    check_eq("mmu_vld", 32'(mmu_flush_vld_o), 32'(e_vld));
    check_eq("dtlb_grant", 32'(dtlb_flush_grant_o), 32'(e_gd));
    check_eq("itlb_grant", 32'(itlb_flush_grant_o), 32'(e_gi));
    check_eq("drain_timeout", 32'(drain_timeout_o), 32'(exp_to));
    if (e_vld) begin
      check_eq("mmu_use_asid", 32'(mmu_flush_use_asid_o), 32'(ep_fld.ua));
      check_eq("mmu_use_vpn", 32'(mmu_flush_use_vpn_o), 32'(ep_fld.uv));
      check_eq("mmu_vpn", 32'(mmu_flush_vpn_o), 32'(ep_fld.vpn));
      check_eq("mmu_asid", 32'(mmu_flush_asid_o), 32'(ep_fld.asid));
    end
    update_agents(c);
    capture(c);
    drive(c);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    en_rand = 0; f_b = 0; f_d = 0;
    reset_model();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    outputs_zero("reset");
    #1 rstn = 1'b0;

    // single DTLB flush, asid-restricted
    start_req(0, mk(1'b1, 1'b0, '0, 16'h5));
    run(8);

    // page walk outstanding for 10 cycles
    f_b = 10;
    start_req(0, mk(1'b0, 1'b1, 27'h1234, '0));
    run(20);

    // contention twice: DTLB then ITLB, then ITLB first
    f_b = 0;
    start_req(0, mk(1'b0, 1'b1, 27'h1, '0));
    start_req(1, mk(1'b0, 1'b1, 27'h2, '0));
    run(14);
    start_req(0, mk(1'b0, 1'b1, 27'h11, '0));
    start_req(1, mk(1'b0, 1'b1, 27'h22, '0));
    run(14);

    // identical requests merge into one flush
    start_req(0, mk(1'b0, 1'b1, 27'h3FF, '0));
    start_req(1, mk(1'b0, 1'b1, 27'h3FF, '0));
    run(8);

    // drain just below the limit, then beyond it, then a normal flush with the flag held
    f_b = DM - 2;
    start_req(1, rand_fl());
    run(DM + 8);
    f_b = DM + 2;
    start_req(0, rand_fl());
    run(DM + 12);
    f_b = 0;
    start_req(1, rand_fl());
    run(8);

    // reset while the flush request is outstanding
    f_d = 6;
    start_req(0, rand_fl());
    run(4);
    #3 rstn = 1'b1;
    #1 outputs_zero("rst_flush");
    @(posedge clk);
    #3 rstn = 1'b0;
    reset_model();
    f_d = 0;
    start_req(0, mk(1'b0, 1'b1, 27'h5, '0));
    start_req(1, mk(1'b0, 1'b1, 27'h6, '0));
    run(14);

    // randomized traffic
    en_rand = 1; f_b = -1; f_d = -1;
    run(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
